ibex_fetch_req_engine: RTL and testbench
========================================

// Module: ibex_fetch_req_engine
// PURPOSE
//  Instruction-fetch request engine sitting directly upstream of the fetch FIFO.
//  Issues word-aligned instruction bus requests, tracks up to NUM_REQS outstanding
//  transactions, discards responses made stale by a branch, and pushes valid
//  responses (addr/rdata/err) into the FIFO. Also drives the FIFO clear on branches.
// PARAMETERS
//  NUM_REQS   2             max outstanding bus requests (>=1); equals FIFO busy width
//  BOOT_ADDR  32'h0000_0080 fetch address loaded at reset (bits [1:0] ignored)
// PORTS
//  clk_i            in   1         clock; all state updates on rising edge
//  rst_i            in   1         reset, synchronous, active-high
//  req_i            in   1         fetch enable from IF stage
//  branch_i         in   1         redirect fetch, 1-cycle pulse
//  branch_addr_i    in   32        redirect target (halfword aligned)
//  fifo_busy_i      in   NUM_REQS  FIFO occupancy; busy[NUM_REQS-1]=1 blocks new requests
//  instr_req_o      out  1         bus request
//  instr_addr_o     out  32        bus address, [1:0]=2'b00
//  instr_gnt_i      in   1         bus grant
//  instr_rvalid_i   in   1         bus response valid (in order)
//  instr_rdata_i    in   32        bus response data
//  instr_err_i      in   1         bus response error
//  fifo_clear_o     out  1         FIFO clear (= branch_i, combinational)
//  fifo_valid_o     out  1         FIFO push
//  fifo_addr_o      out  32        address of pushed word
//  fifo_rdata_o     out  32        = instr_rdata_i
//  fifo_err_o       out  1         = instr_err_i
//  busy_o           out  1         instr_req_o | (outstanding != 0)
// BEHAVIOUR
//  Reset (rst_i=1 at edge): fetch_addr<=BOOT_ADDR&~3, outstanding<=0, all discard
//   flags<=0, state<=IDLE, unaligned flag<=0. Outputs after reset: instr_req_o=0,
//   fifo_valid_o=0, busy_o=0; fifo_clear_o follows branch_i. Reset mid-transfer
//   drops all tracking; later rvalid with outstanding==0 is ignored (no push).
//  FSM: IDLE: instr_req_o=0. Go REQ when req_i & (outstanding<NUM_REQS)
//   & ~fifo_busy_i[NUM_REQS-1], or on branch_i (regardless of req_i).
//   REQ: instr_req_o=1, instr_addr_o=fetch_addr, held stable until instr_gnt_i.
//   On gnt: push {addr,discard=0} into slot queue, fetch_addr+=4 (wraps mod 2^32),
//   stay REQ if issue condition still holds next cycle else IDLE.
//  Branch: fetch_addr<={branch_addr_i[31:2],2'b00}; every queued slot marked discard;
//   unaligned flag<=branch_addr_i[1]. If in REQ without gnt, the held request stays
//   on the bus unchanged, is marked discard at grant, then target is issued.
//   Earliest target request: cycle N+1 after branch in cycle N.
//  Response: on instr_rvalid_i pop oldest slot; fifo_valid_o = rvalid & ~slot.discard
//   & ~branch_i & (outstanding!=0). fifo_addr_o = slot addr, with bit[1] = unaligned
//   flag for first non-discarded response after a branch; flag cleared on that push.
//  Counting: outstanding +1 on gnt, -1 on rvalid, unchanged when both same cycle;
//   never exceeds NUM_REQS.
//  Simultaneous: branch+rvalid -> no push; branch+gnt -> granted slot discarded;
//   rst_i overrides all.
//  Error responses are pushed like data (fifo_err_o=1); fetching continues.
// TESTING
//  1 Reset, req_i=1, gnt same cycle, rvalid 1 cycle later -> addrs 0x80,0x84 on bus;
//    FIFO pushes addr 0x80 rdata as driven; busy_o=0 after reset.
//  2 NUM_REQS=2, gnt every cycle, rvalid withheld -> exactly 2 grants, instr_req_o
//    low until first rvalid; outstanding never 3.
//  3 Two outstanding, branch_i to 0x1002 -> fifo_clear_o=1 same cycle, both old
//    responses not pushed, next bus addr 0x1000, first push fifo_addr_o=0x1002.
//  4 Branch while REQ stalled (gnt=0) at 0x88 -> addr stays 0x88 until gnt, that
//    response dropped, then request at target.
//  5 instr_err_i=1 on response -> fifo_valid_o=1, fifo_err_o=1, next request issued.
//  6 rst_i mid-transfer with 1 outstanding, late rvalid after reset -> no push,
//    next request at 0x80.

Source files
------------

// File: rtl/ibex_fetch_req_engine_if.sv
// rtl/ibex_fetch_req_engine_if.sv - instruction bus and fetch FIFO push signals
interface ibex_fetch_req_engine_if;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        instr_err;

   logic        fifo_valid;
   logic [31:0] fifo_addr;
   logic [31:0] fifo_rdata;
   logic        fifo_err;

   modport master (
      output instr_req, instr_addr,
      input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
      output fifo_valid, fifo_addr, fifo_rdata, fifo_err
   );

   modport slave (
      input  instr_req, instr_addr,
      output instr_gnt, instr_rvalid, instr_rdata, instr_err,
      input  fifo_valid, fifo_addr, fifo_rdata, fifo_err
   );
endinterface

// File: rtl/ibex_fetch_req_engine.sv
// rtl/ibex_fetch_req_engine.sv - fetch request engine feeding the fetch FIFO
module ibex_fetch_req_engine #(
   parameter int unsigned NUM_REQS  = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_i,
   input  logic                     branch_i,
   input  logic [31:0]              branch_addr_i,
   input  logic [NUM_REQS-1:0]      fifo_busy_i,
   ibex_fetch_req_engine_if.master  bus,
   output logic                     fifo_clear_o,
   output logic                     busy_o
);

   localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REQS - 1);
   localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(NUM_REQS);

   typedef enum logic {
      IDLE,
      REQ
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          fetch_addr_q, fetch_addr_d;
   logic [31:2]          tgt_q, tgt_d;
   logic                 stale_q, stale_d;
   logic                 redir_q, redir_d;
   logic                 unal_q, unal_d;
   logic [CNT_W-1:0]     out_q, out_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [NUM_REQS-1:0]  disc_q, disc_d;
   logic [29:0]          slot_addr_q [NUM_REQS];

   logic                 instr_req;
   logic                 gnt_acc;
   logic                 pop;
   logic                 push;
   logic                 cap_d;
   logic                 want_issue;
   logic                 unused_inputs;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign unused_inputs = ^{branch_addr_i[0], fifo_busy_i};

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      tgt_d        = tgt_q;
      stale_d      = stale_q;
      redir_d      = redir_q;
      unal_d       = unal_q;
      disc_d       = disc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;

      instr_req = (state_q == REQ);
      gnt_acc   = instr_req & bus.instr_gnt;
      pop       = bus.instr_rvalid & (out_q != '0);
      push      = pop & ~disc_q[rd_ptr_q] & ~branch_i;
      out_d     = out_q + CNT_W'(gnt_acc) - CNT_W'(pop);

      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      // A stale held request is granted at its old address, then the saved target follows.
      if (gnt_acc) begin
         wr_ptr_d         = ptr_inc(wr_ptr_q);
         disc_d[wr_ptr_q] = stale_q;
         fetch_addr_d     = stale_q ? {tgt_q, 2'b00} : fetch_addr_q + 32'd4;
         stale_d          = 1'b0;
         if (!stale_q) begin
            redir_d = 1'b0;
         end
      end

      if (push) begin
         unal_d = 1'b0;
      end

      if (branch_i) begin
         disc_d  = '1;
         redir_d = 1'b1;
         unal_d  = branch_addr_i[1];
         if (instr_req && !bus.instr_gnt) begin
            stale_d = 1'b1;
            tgt_d   = branch_addr_i[31:2];
         end else begin
            fetch_addr_d = {branch_addr_i[31:2], 2'b00};
         end
      end

      // A pending redirect keeps fetching alive even after req_i drops.
      cap_d      = (out_d < MAX_OUT);
      want_issue = (req_i & ~fifo_busy_i[NUM_REQS-1]) | branch_i | redir_d;

      unique case (state_q)
         IDLE: begin
            if (cap_d && want_issue) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (gnt_acc && !(cap_d && want_issue)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fetch_addr_q <= BOOT_ADDR & ~32'h3;
         tgt_q        <= '0;
         stale_q      <= 1'b0;
         redir_q      <= 1'b0;
         unal_q       <= 1'b0;
         out_q        <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         disc_q       <= '0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         tgt_q        <= tgt_d;
         stale_q      <= stale_d;
         redir_q      <= redir_d;
         unal_q       <= unal_d;
         out_q        <= out_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         disc_q       <= disc_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && gnt_acc) begin
         slot_addr_q[wr_ptr_q] <= fetch_addr_q[31:2];
      end
   end

   assign bus.instr_req  = instr_req;
   assign bus.instr_addr = fetch_addr_q;
   assign bus.fifo_valid = push;
   assign bus.fifo_addr  = {slot_addr_q[rd_ptr_q], unal_q, 1'b0};
   assign bus.fifo_rdata = bus.instr_rdata;
   assign bus.fifo_err   = bus.instr_err;
   assign fifo_clear_o   = branch_i;
   assign busy_o         = instr_req | (out_q != '0);

endmodule

// File: tb/tb_ibex_fetch_req_engine.sv
// tb/tb_ibex_fetch_req_engine.sv - scoreboard bench for the fetch request engine
module tb_ibex_fetch_req_engine;

   logic        clk;
   logic        rst;
   logic        req;
   logic        branch;
   logic [31:0] branch_addr;
   logic [1:0]  fifo_busy;
   logic        fifo_clear;
   logic        busy;

   ibex_fetch_req_engine_if bus ();

   ibex_fetch_req_engine #(
      .NUM_REQS  (2),
      .BOOT_ADDR (32'h0000_0080)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .branch_i      (branch),
      .branch_addr_i (branch_addr),
      .fifo_busy_i   (fifo_busy),
      .bus           (bus),
      .fifo_clear_o  (fifo_clear),
      .busy_o        (busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        err;
   } push_t;

   push_t exp_q[$];
   int    checks;
   int    errors;
   int    gnt_cnt;
   int    gnt_base;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_push(input logic [31:0] a, input logic [31:0] d, input logic e);
      push_t p;
      p.addr  = a;
      p.rdata = d;
      p.err   = e;
      exp_q.push_back(p);
   endtask

   // Inputs change just after a rising edge; the caller checks at the following falling edge.
   task automatic cyc(input logic r, input logic b, input logic g, input logic rv,
                      input logic [31:0] rd, input logic e);
      @(posedge clk);
      #1;
      req              = r;
      branch           = b;
      bus.instr_gnt    = g;
      bus.instr_rvalid = rv;
      bus.instr_rdata  = rd;
      bus.instr_err    = e;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst              = 1'b1;
      req              = 1'b0;
      branch           = 1'b0;
      bus.instr_gnt    = 1'b0;
      bus.instr_rvalid = 1'b0;
      bus.instr_rdata  = '0;
      bus.instr_err    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      gnt_cnt          = 0;
      gnt_base         = 0;
      rst              = 1'b1;
      req              = 1'b0;
      branch           = 1'b0;
      branch_addr      = '0;
      fifo_busy        = '0;
      bus.instr_gnt    = 1'b0;
      bus.instr_rvalid = 1'b0;
      bus.instr_rdata  = '0;
      bus.instr_err    = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (bus.instr_req && bus.instr_gnt) gnt_cnt++;
            if (bus.fifo_valid) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_push: got addr=%h rdata=%h err=%b expected none",
                           bus.fifo_addr, bus.fifo_rdata, bus.fifo_err);
               end else begin
                  push_t p;
                  p = exp_q.pop_front();
                  if (bus.fifo_addr !== p.addr || bus.fifo_rdata !== p.rdata || bus.fifo_err !== p.err) begin
                     errors++;
                     $display("FAIL push: got addr=%h rdata=%h err=%b expected addr=%h rdata=%h err=%b",
                              bus.fifo_addr, bus.fifo_rdata, bus.fifo_err, p.addr, p.rdata, p.err);
                  end
               end
            end
         end
      join_none

      // Reset state, then boot fetch
      do_reset();
      chk("rst_req",   32'(bus.instr_req),  32'd0);
      chk("rst_busy",  32'(busy),           32'd0);
      chk("rst_valid", 32'(bus.fifo_valid), 32'd0);
      chk("rst_clear", 32'(fifo_clear),     32'd0);

      cyc(1, 0, 0, 0, 32'h0, 0);
      chk("t1_idle_req", 32'(bus.instr_req), 32'd0);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t1_req", 32'(bus.instr_req), 32'd1);
      chk("t1_addr0", bus.instr_addr, 32'h0000_0080);
      expect_push(32'h0000_0080, 32'h1111_0080, 1'b0);
      cyc(0, 0, 0, 1, 32'h1111_0080, 0);
      chk("t1_addr1", bus.instr_addr, 32'h0000_0084);
      chk("t1_valid", 32'(bus.fifo_valid), 32'd1);
      cyc(0, 0, 1, 0, 32'h0, 0);
      chk("t1_addr1_gnt", bus.instr_addr, 32'h0000_0084);
      expect_push(32'h0000_0084, 32'h2222_0084, 1'b0);
      cyc(0, 0, 0, 1, 32'h2222_0084, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("t1_busy_end", 32'(busy), 32'd0);

      // Branch while the request at 0x88 is stalled
      cyc(1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, 0);
      chk("t4_addr_a", bus.instr_addr, 32'h0000_0088);
      branch_addr = 32'h0000_2000;
      cyc(1, 1, 0, 0, 32'h0, 0);
      chk("t4_clear", 32'(fifo_clear), 32'd1);
      chk("t4_addr_b", bus.instr_addr, 32'h0000_0088);
      cyc(1, 0, 0, 0, 32'h0, 0);
      chk("t4_addr_c", bus.instr_addr, 32'h0000_0088);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t4_addr_d", bus.instr_addr, 32'h0000_0088);
      cyc(0, 0, 1, 1, 32'hBAD0_0088, 0);
      chk("t4_tgt", bus.instr_addr, 32'h0000_2000);
      chk("t4_drop", 32'(bus.fifo_valid), 32'd0);
      expect_push(32'h0000_2000, 32'h3333_2000, 1'b0);
      cyc(0, 0, 0, 1, 32'h3333_2000, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("t4_busy_end", 32'(busy), 32'd0);

      // Grant every cycle with responses withheld: capacity limits to two
      gnt_base = gnt_cnt;
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_idle", 32'(bus.instr_req), 32'd0);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_addr0", bus.instr_addr, 32'h0000_2004);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_addr1", bus.instr_addr, 32'h0000_2008);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_full_a", 32'(bus.instr_req), 32'd0);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_full_b", 32'(bus.instr_req), 32'd0);
      expect_push(32'h0000_2004, 32'h4444_2004, 1'b0);
      cyc(1, 0, 1, 1, 32'h4444_2004, 0);
      chk("t2_full_c", 32'(bus.instr_req), 32'd0);
      chk("t2_grants", 32'(gnt_cnt - gnt_base), 32'd2);
      expect_push(32'h0000_2008, 32'h5555_2008, 1'b0);
      cyc(1, 0, 1, 1, 32'h5555_2008, 0);
      chk("t2_resume", bus.instr_addr, 32'h0000_200C);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t2_addr3", bus.instr_addr, 32'h0000_2010);

      // Branch to unaligned target with two outstanding
      branch_addr = 32'h0000_1002;
      cyc(1, 1, 1, 0, 32'h0, 0);
      chk("t3_clear", 32'(fifo_clear), 32'd1);
      chk("t3_req", 32'(bus.instr_req), 32'd0);
      cyc(1, 0, 0, 1, 32'hBAD0_200C, 0);
      chk("t3_drop0", 32'(bus.fifo_valid), 32'd0);
      cyc(1, 0, 1, 1, 32'hBAD0_2010, 0);
      chk("t3_drop1", 32'(bus.fifo_valid), 32'd0);
      chk("t3_tgt", bus.instr_addr, 32'h0000_1000);
      expect_push(32'h0000_1002, 32'h6666_1000, 1'b0);
      cyc(1, 0, 1, 1, 32'h6666_1000, 0);
      chk("t3_fifo_addr", bus.fifo_addr, 32'h0000_1002);
      chk("t3_addr_next", bus.instr_addr, 32'h0000_1004);

      // Error response is pushed and fetching continues
      expect_push(32'h0000_1004, 32'h7777_1004, 1'b1);
      cyc(0, 0, 0, 1, 32'h7777_1004, 1);
      chk("t5_err", 32'(bus.fifo_err), 32'd1);
      chk("t5_req", 32'(bus.instr_req), 32'd1);
      chk("t5_addr", bus.instr_addr, 32'h0000_1008);
      cyc(1, 0, 1, 0, 32'h0, 0);

      // Reset with one outstanding; the late response must be ignored
      do_reset();
      chk("t6_busy", 32'(busy), 32'd0);
      cyc(0, 0, 0, 1, 32'hBAD0_1008, 0);
      chk("t6_late", 32'(bus.fifo_valid), 32'd0);
      cyc(1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 1, 0, 32'h0, 0);
      chk("t6_addr", bus.instr_addr, 32'h0000_0080);
      expect_push(32'h0000_0080, 32'h8888_0080, 1'b0);
      cyc(0, 0, 0, 1, 32'h8888_0080, 0);
      cyc(0, 0, 1, 0, 32'h0, 0);
      chk("t6_addr1", bus.instr_addr, 32'h0000_0084);
      expect_push(32'h0000_0084, 32'h9999_0084, 1'b0);
      cyc(0, 0, 0, 1, 32'h9999_0084, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("t6_busy_end", 32'(busy), 32'd0);

      repeat (3) cyc(0, 0, 0, 0, 32'h0, 0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
